// File: rtl/mips_pkg.sv
// Shared MIPS data-memory definitions: store size encodings, store_narrower states,
// lane count and the store alignment check.
package mips_pkg;

    localparam int LANES = 4;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;
    localparam logic [1:0] SIZE_RSVD = 2'b11;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StRead  = 2'd1,
        StMerge = 2'd2,
        StWrite = 2'd3
    } sn_state_e;

    // True when the request must be trapped rather than stored.
    function automatic logic is_misaligned(input logic [1:0] addr_lo, input logic [1:0] size);
        logic w_mis;
        case (size)
            SIZE_BYTE: w_mis = 1'b0;
            SIZE_HALF: w_mis = addr_lo[0];
            SIZE_WORD: w_mis = |addr_lo;
            default:   w_mis = 1'b1;
        endcase
        return w_mis;
    endfunction

endpackage

// File: rtl/byte_merge.sv
// Combinational lane merge: replaces the byte/halfword lane(s) selected by address and size
// in an old memory word with the low bits of the new data; word size passes data through.
module byte_merge
    import mips_pkg::*;
(
    input  logic [LANES*8-1:0] i_old,
    input  logic [LANES*8-1:0] i_new,
    input  logic [1:0]         i_addr_lo,
    input  logic [1:0]         i_size,
    output logic [LANES*8-1:0] o_merged
);

    logic [LANES-1:0]   w_lane_en;
    logic [LANES*8-1:0] w_src;

    always_comb begin
        w_lane_en = {LANES{1'b1}};
        w_src     = i_new;
        case (i_size)
            SIZE_BYTE: begin
                w_lane_en = LANES'(1) << i_addr_lo;
                w_src     = {LANES{i_new[7:0]}};
            end
            SIZE_HALF: begin
                w_lane_en = i_addr_lo[1] ? 4'b1100 : 4'b0011;
                w_src     = {2{i_new[15:0]}};
            end
            default: begin
                w_lane_en = {LANES{1'b1}};
                w_src     = i_new;
            end
        endcase
    end

    always_comb begin
        o_merged = i_old;
        for (int k = 0; k < LANES; k++) begin
            if (w_lane_en[k]) begin
                o_merged[8*k +: 8] = w_src[8*k +: 8];
            end
        end
    end

endmodule

// File: rtl/store_narrower.sv
// Narrows MEM-stage stores to byte/half/word using read-modify-write for sub-word sizes.
// Optional MISALIGN_TRAP_EN: misaligned or reserved-size requests finish with o_err, no access.
module store_narrower
    import mips_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_valid,
    output logic                  o_ready,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    input  logic [1:0]            i_size,
    input  logic [DATA_WIDTH-1:0] i_data,
    output logic                  o_done,
    output logic                  o_err,
    output logic [ADDR_WIDTH-1:0] o_mem_addr,
    output logic                  o_mem_re,
    input  logic [DATA_WIDTH-1:0] i_mem_rdata,
    output logic                  o_mem_we,
    output logic [DATA_WIDTH-1:0] o_mem_wdata
);

    sn_state_e             r_state;
    sn_state_e             w_state_next;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [1:0]            r_size;
    logic [DATA_WIDTH-1:0] r_data;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic                  r_err;

    logic                  w_accept;
    logic                  w_trap;
    logic                  w_rmw;
    logic                  w_in_merge;
    logic [DATA_WIDTH-1:0] w_old;
    logic [DATA_WIDTH-1:0] w_new;
    logic [1:0]            w_addr_lo;
    logic [1:0]            w_size;
    logic [DATA_WIDTH-1:0] w_merged;

    assign w_accept = i_valid && (r_state == StIdle);
    assign w_rmw    = (i_size == SIZE_BYTE) || (i_size == SIZE_HALF);

`ifdef MISALIGN_TRAP_EN
    assign w_trap = is_misaligned(i_addr[1:0], i_size);
`else
    assign w_trap = 1'b0;
`endif

    // One merge unit: fed from the request in IDLE (word path) and from registers in MERGE.
    assign w_in_merge = (r_state == StMerge);
    assign w_old      = w_in_merge ? i_mem_rdata : '0;
    assign w_new      = w_in_merge ? r_data : i_data;
    assign w_addr_lo  = w_in_merge ? r_addr[1:0] : i_addr[1:0];
    assign w_size     = w_in_merge ? r_size : i_size;

    byte_merge u_byte_merge (
        .i_old     (w_old),
        .i_new     (w_new),
        .i_addr_lo (w_addr_lo),
        .i_size    (w_size),
        .o_merged  (w_merged)
    );

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle: begin
                if (w_accept) begin
                    if (w_trap || !w_rmw) begin
                        w_state_next = StWrite;
                    end else begin
                        w_state_next = StRead;
                    end
                end
            end
            StRead:  w_state_next = StMerge;
            StMerge: w_state_next = StWrite;
            StWrite: w_state_next = StIdle;
            default: w_state_next = StIdle;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= StIdle;
            r_addr  <= '0;
            r_size  <= '0;
            r_data  <= '0;
            r_wdata <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (w_accept) begin
                r_addr  <= i_addr;
                r_size  <= i_size;
                r_data  <= i_data;
                r_err   <= w_trap;
                r_wdata <= w_merged;
            end else if (w_in_merge) begin
                r_wdata <= w_merged;
            end
        end
    end

    assign o_ready     = (r_state == StIdle);
    assign o_mem_re    = (r_state == StRead);
    assign o_mem_we    = (r_state == StWrite) && !r_err;
    assign o_done      = (r_state == StWrite);
    assign o_mem_addr  = {r_addr[ADDR_WIDTH-1:2], 2'b00};
    assign o_mem_wdata = o_mem_we ? r_wdata : '0;

`ifdef MISALIGN_TRAP_EN
    assign o_err = (r_state == StWrite) && r_err;
`else
    assign o_err = 1'b0;
`endif

endmodule

// File: tb/tb_store_narrower.sv
// Directed bench for store_narrower with a word-addressed memory model and a write scoreboard.
module tb_store_narrower;
    import mips_pkg::*;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic        i_valid;
    logic [31:0] i_addr;
    logic [1:0]  i_size;
    logic [31:0] i_data;
    logic [31:0] i_mem_rdata = 32'h0;
    logic        o_ready, o_done, o_err, o_mem_re, o_mem_we;
    logic [31:0] o_mem_addr, o_mem_wdata;

    int total = 0;
    int bad   = 0;
    int waited;

    logic [63:0] sb_q[$];
    logic [31:0] mem[int];

    store_narrower #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_valid     (i_valid),
        .o_ready     (o_ready),
        .i_addr      (i_addr),
        .i_size      (i_size),
        .i_data      (i_data),
        .o_done      (o_done),
        .o_err       (o_err),
        .o_mem_addr  (o_mem_addr),
        .o_mem_re    (o_mem_re),
        .i_mem_rdata (i_mem_rdata),
        .o_mem_we    (o_mem_we),
        .o_mem_wdata (o_mem_wdata)
    );

    always #5 i_clk = ~i_clk;

    // Single-port synchronous RAM model: read data valid the cycle after o_mem_re.
    always @(posedge i_clk) begin
        if (o_mem_re) begin
            i_mem_rdata <= mem.exists(int'(o_mem_addr >> 2)) ? mem[int'(o_mem_addr >> 2)] : 32'h0;
        end
        if (o_mem_we) begin
            mem[int'(o_mem_addr >> 2)] = o_mem_wdata;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic [31:0] addr, input logic [1:0] size, input logic [31:0] data);
        i_addr  = addr;
        i_size  = size;
        i_data  = data;
        i_valid = 1'b1;
    endtask

    // Called at a negedge with a request already driven; follows it to the return of o_ready.
    task automatic run_store(input string tag, input int exp_re, input int exp_done,
                             input bit exp_wr, input bit exp_err, input int exp_ready,
                             input bit keep, input logic [31:0] n_addr,
                             input logic [1:0] n_size, input logic [31:0] n_data,
                             output int n_wait);
        int          re_at    = 0;
        int          we_at    = 0;
        int          done_at  = 0;
        int          done_cnt = 0;
        int          ready_at = 0;
        logic        err_at   = 1'b0;
        logic [31:0] re_addr  = 32'h0;
        logic [63:0] e;
        n_wait = 0;
        while (!o_ready && n_wait < 20) begin
            @(negedge i_clk);
            n_wait++;
        end
        chk({tag, "_accept"}, {31'b0, o_ready}, 32'd1);
        @(negedge i_clk);
        if (keep) issue(n_addr, n_size, n_data);
        else i_valid = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            chk({tag, "_re_we_excl"}, {31'b0, o_mem_re & o_mem_we}, 32'd0);
            if (o_mem_re && re_at == 0) begin
                re_at   = k;
                re_addr = o_mem_addr;
            end
            if (o_mem_we) begin
                we_at = k;
                chk({tag, "_sb_pending"}, {31'b0, sb_q.size() != 0}, 32'd1);
                if (sb_q.size() != 0) begin
                    e = sb_q.pop_front();
                    chk({tag, "_waddr"}, o_mem_addr, e[63:32]);
                    chk({tag, "_wdata"}, o_mem_wdata, e[31:0]);
                    if (re_at != 0) chk({tag, "_addr_stable"}, o_mem_addr, re_addr);
                end
            end else begin
                chk({tag, "_wdata_idle"}, o_mem_wdata, 32'h0);
            end
            if (o_done) begin
                done_cnt++;
                done_at = k;
                err_at  = o_err;
            end else begin
                chk({tag, "_err_nodone"}, {31'b0, o_err}, 32'd0);
            end
            if (o_ready) begin
                ready_at = k;
                break;
            end
            @(negedge i_clk);
        end
        chk({tag, "_re_cycle"}, re_at, exp_re);
        chk({tag, "_done_cnt"}, done_cnt, 32'd1);
        chk({tag, "_done_cycle"}, done_at, exp_done);
        chk({tag, "_we_cycle"}, we_at, exp_wr ? exp_done : 0);
        chk({tag, "_err"}, {31'b0, err_at}, {31'b0, exp_err});
        chk({tag, "_ready_cycle"}, ready_at, exp_ready);
    endtask

    initial begin
        i_rst   = 1'b1;
        i_valid = 1'b0;
        i_addr  = 32'h0;
        i_size  = 2'b00;
        i_data  = 32'h0;
        mem['h080] = 32'h11223344;
        mem['h0C0] = 32'h11223344;
        mem['h100] = 32'h11223344;
        mem['h140] = 32'hAABBCCDD;
        #1;
        chk("rst_ready", {31'b0, o_ready}, 32'd1);
        chk("rst_re", {31'b0, o_mem_re}, 32'd0);
        chk("rst_we", {31'b0, o_mem_we}, 32'd0);
        chk("rst_done", {31'b0, o_done}, 32'd0);
        chk("rst_err", {31'b0, o_err}, 32'd0);
        chk("rst_addr", o_mem_addr, 32'h0);
        chk("rst_wdata", o_mem_wdata, 32'h0);
        repeat (2) @(negedge i_clk);
        i_rst = 1'b0;
        @(negedge i_clk);

        sb_q.push_back({32'h100, 32'hDEADBEEF});
        issue(32'h100, SIZE_WORD, 32'hDEADBEEF);
        run_store("word", 0, 1, 1, 0, 2, 0, 32'h0, 2'b00, 32'h0, waited);

        sb_q.push_back({32'h200, 32'hAB223344});
        issue(32'h203, SIZE_BYTE, 32'h123456AB);
        run_store("byte3", 1, 3, 1, 0, 4, 0, 32'h0, 2'b00, 32'h0, waited);

        sb_q.push_back({32'h300, 32'hCAFE3344});
        issue(32'h302, SIZE_HALF, 32'hFFFFCAFE);
        run_store("half2", 1, 3, 1, 0, 4, 0, 32'h0, 2'b00, 32'h0, waited);

        sb_q.push_back({32'h500, 32'hAABB77DD});
        issue(32'h501, SIZE_BYTE, 32'h00000077);
        run_store("byte1", 1, 3, 1, 0, 4, 0, 32'h0, 2'b00, 32'h0, waited);

        // Requester holds i_valid with the next request while the sub-word store is busy.
        sb_q.push_back({32'h500, 32'hAABBBEEF});
        sb_q.push_back({32'h504, 32'h0BADF00D});
        issue(32'h500, SIZE_HALF, 32'h1234BEEF);
        run_store("b2b_half", 1, 3, 1, 0, 4, 1, 32'h504, SIZE_WORD, 32'h0BADF00D, waited);
        run_store("b2b_word", 0, 1, 1, 0, 2, 0, 32'h0, 2'b00, 32'h0, waited);
        chk("b2b_wait", waited, 32'd0);

        // Reset pulsed while a byte store is in MERGE.
        issue(32'h400, SIZE_BYTE, 32'h00000055);
        @(negedge i_clk);
        i_valid = 1'b0;
        chk("rst_mid_read", {31'b0, o_mem_re}, 32'd1);
        @(negedge i_clk);
        chk("rst_mid_busy", {31'b0, o_ready}, 32'd0);
        i_rst = 1'b1;
        #1;
        chk("rst_mid_ready", {31'b0, o_ready}, 32'd1);
        chk("rst_mid_we", {31'b0, o_mem_we}, 32'd0);
        chk("rst_mid_re", {31'b0, o_mem_re}, 32'd0);
        chk("rst_mid_done", {31'b0, o_done}, 32'd0);
        chk("rst_mid_err", {31'b0, o_err}, 32'd0);
        chk("rst_mid_addr", o_mem_addr, 32'h0);
        chk("rst_mid_wdata", o_mem_wdata, 32'h0);
        @(negedge i_clk);
        i_rst = 1'b0;
        repeat (3) begin
            @(negedge i_clk);
            chk("rst_after_we", {31'b0, o_mem_we}, 32'd0);
            chk("rst_after_done", {31'b0, o_done}, 32'd0);
        end

        sb_q.push_back({32'h400, 32'h11223399});
        issue(32'h400, SIZE_BYTE, 32'hFFFFFF99);
        run_store("post_rst", 1, 3, 1, 0, 4, 0, 32'h0, 2'b00, 32'h0, waited);

`ifdef MISALIGN_TRAP_EN
        issue(32'h401, SIZE_HALF, 32'h0000ABCD);
        run_store("mis_half", 0, 1, 0, 1, 2, 0, 32'h0, 2'b00, 32'h0, waited);
        issue(32'h600, SIZE_RSVD, 32'h01020304);
        run_store("rsvd", 0, 1, 0, 1, 2, 0, 32'h0, 2'b00, 32'h0, waited);
        issue(32'h702, SIZE_WORD, 32'hCAFEBABE);
        run_store("mis_word", 0, 1, 0, 1, 2, 0, 32'h0, 2'b00, 32'h0, waited);
`else
        sb_q.push_back({32'h400, 32'h1122ABCD});
        issue(32'h401, SIZE_HALF, 32'h0000ABCD);
        run_store("mis_half", 1, 3, 1, 0, 4, 0, 32'h0, 2'b00, 32'h0, waited);
        sb_q.push_back({32'h600, 32'h01020304});
        issue(32'h600, SIZE_RSVD, 32'h01020304);
        run_store("rsvd", 0, 1, 1, 0, 2, 0, 32'h0, 2'b00, 32'h0, waited);
        sb_q.push_back({32'h700, 32'hCAFEBABE});
        issue(32'h702, SIZE_WORD, 32'hCAFEBABE);
        run_store("mis_word", 0, 1, 1, 0, 2, 0, 32'h0, 2'b00, 32'h0, waited);
`endif

        chk("sb_empty", sb_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
